data_ram: RTL and testbench

Byte-addressable 32-bit data memory for the RV052B RISC-V core, serving LB/LH/LW/LBU/LHU loads and SB/SH/SW stores.
- Address is formed from a base operand plus an immediate.
- An operation is launched by a one-cycle start pulse and completes with a one-cycle done pulse.
- Sits in the MEM stage and is driven by the execute/control logic.

---
 rtl/data_ram_if.sv | 24 ++
 rtl/data_ram.sv | 101 ++++++++++
 tb/tb_data_ram.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/data_ram_if.sv
// Request/response bundle between the MEM-stage control logic and the data RAM.
// The master side issues a one-cycle start strobe with the operands and mode.
// The slave side returns a one-cycle done pulse and the load result.
interface data_ram_if;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [31:0] imm_data;
  logic        start;
  logic [1:0]  use_part;
  logic [1:0]  op_mode1;
  logic [2:0]  op_mode2;
  logic        done;
  logic [31:0] res;

  modport master (
    output op1, op2, imm_data, start, use_part, op_mode1, op_mode2,
    input  done, res
  );

  modport slave (
    input  op1, op2, imm_data, start, use_part, op_mode1, op_mode2,
    output done, res
  );
endinterface

// File: rtl/data_ram.sv
// Byte-addressable 32-bit data memory: LB/LH/LW/LBU/LHU loads, SB/SH/SW stores.
// Latency: one cycle; done and res are registered on the edge that samples start.
// No backpressure: fully pipelined, a new request can be accepted every cycle.
module data_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_BITS   = 8
) (
  input logic       clk,
  input logic       rst,
  data_ram_if.slave bus
);

  localparam logic [1:0] UP_LOAD  = 2'b01;
  localparam logic [1:0] UP_STORE = 2'b10;

  logic [31:0]          mem [DEPTH_WORDS];

  logic [31:0]          ea;
  logic [ADDR_BITS-1:0] idx;
  logic [1:0]           lane;
  logic [31:0]          rd_word;
  logic [7:0]           rd_byte;
  logic [15:0]          rd_half;
  logic [31:0]          load_val;
  logic [3:0]           be;
  logic [31:0]          wdata;
  logic                 unused_ea_hi;

  // Effective address selection; sums wrap naturally at 32 bits.
  always_comb begin
    case (bus.op_mode1)
      2'b01:   ea = bus.op1;
      2'b10:   ea = bus.imm_data;
      default: ea = bus.op1 + bus.imm_data;
    endcase
  end

  // Upper address bits beyond the array are deliberately discarded (wrap).
  assign idx          = ea[ADDR_BITS+1:2];
  assign lane         = ea[1:0];
  assign unused_ea_hi = &{1'b0, ea[31:ADDR_BITS+2]};

  assign rd_word = mem[idx];
  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

  // Load result formatting by width and sign; reserved encodings read as zero.
  always_comb begin
    load_val = 32'h0;
    case (bus.op_mode2)
      3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b010:  load_val = rd_word;
      3'b100:  load_val = {24'h0, rd_byte};
      3'b101:  load_val = {16'h0, rd_half};
      default: load_val = 32'h0;
    endcase
  end

  // Store byte enables and lane-replicated write data; unknown widths write nothing.
  always_comb begin
    be    = 4'b0000;
    wdata = bus.op2;
    case (bus.op_mode2)
      3'b000: begin
        be    = 4'b0001 << lane;
        wdata = {4{bus.op2[7:0]}};
      end
      3'b001: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.op2[15:0]}};
      end
      3'b010: begin
        be    = 4'b1111;
        wdata = bus.op2;
      end
      default: be = 4'b0000;
    endcase
  end

  // Array write; reset blocks the write but never clears stored contents.
  always_ff @(posedge clk) begin
    if (rst && bus.start && (bus.use_part == UP_STORE)) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Completion pulse per accepted request; res only moves on a completed load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.done <= 1'b0;
      bus.res  <= 32'h0;
    end else begin
      bus.done <= bus.start;
      if (bus.start && (bus.use_part == UP_LOAD)) bus.res <= load_val;
    end
  end

endmodule

// File: tb/tb_data_ram.sv
// Randomized + directed bench for data_ram with a byte-array reference model.
// Stimulus pushes expected responses tagged with the cycle they are due.
// A monitor pops them when due and flags any stray or missing done pulse.
module tb_data_ram;
  localparam int DEPTH = 256;
  localparam int ABITS = 8;
  localparam int NBYTES = 4 * DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  data_ram_if bus ();

  data_ram #(.DEPTH_WORDS(DEPTH), .ADDR_BITS(ABITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [31:0] res;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          mon_on = 1'b0;
  logic [7:0]  mm [NBYTES];
  logic [31:0] m_res;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare whenever an expected response falls due, else expect idle.
  always @(negedge clk) begin
    if (mon_on) begin
      if (q.size() != 0 && q[0].tag == cyc) begin
        exp_t e;
        e = q.pop_front();
        check("done", {31'h0, bus.done}, 32'h1);
        check("res", bus.res, e.res);
      end else begin
        check("idle_done", {31'h0, bus.done}, 32'h0);
      end
    end
  end

  // Reference model: spec rules on a flat byte array.
  function automatic logic [31:0] m_addr(input logic [1:0] m1, input logic [31:0] a, input logic [31:0] i);
    logic [31:0] ea;
    if (m1 == 2'b01) ea = a;
    else if (m1 == 2'b10) ea = i;
    else ea = a + i;
    return ea % NBYTES;
  endfunction

  task automatic model(input logic [1:0] up, input logic [2:0] m2, input logic [31:0] addr,
                       input logic [31:0] d);
    int wb, hb, b;
    logic [31:0] w;
    logic [15:0] h;
    logic [7:0]  by;
    b  = int'(addr);
    wb = b - (b % 4);
    hb = b - (b % 2);
    w  = {mm[wb+3], mm[wb+2], mm[wb+1], mm[wb]};
    h  = {mm[hb+1], mm[hb]};
    by = mm[b];
    if (up == 2'b01) begin
      case (m2)
        3'd0:    m_res = (by >= 8'd128) ? 32'hFFFF_FF00 + by : 32'(by);
        3'd1:    m_res = (h >= 16'd32768) ? 32'hFFFF_0000 + h : 32'(h);
        3'd2:    m_res = w;
        3'd4:    m_res = 32'(by);
        3'd5:    m_res = 32'(h);
        default: m_res = 32'h0;
      endcase
    end else if (up == 2'b10) begin
      if (m2 == 3'd0) mm[b] = d[7:0];
      if (m2 == 3'd1) begin mm[hb] = d[7:0]; mm[hb+1] = d[15:8]; end
      if (m2 == 3'd2) for (int k = 0; k < 4; k++) mm[wb+k] = d[8*k +: 8];
    end
  endtask

  // Issue one request in the current cycle; optional fixed expected value.
  task automatic issue(input logic [1:0] up, input logic [2:0] m2, input logic [1:0] m1,
                       input logic [31:0] a, input logic [31:0] i, input logic [31:0] d,
                       input bit use_k, input logic [31:0] k);
    exp_t e;
    bus.start = 1'b1; bus.use_part = up; bus.op_mode2 = m2; bus.op_mode1 = m1;
    bus.op1 = a; bus.imm_data = i; bus.op2 = d;
    model(up, m2, m_addr(m1, a, i), d);
    e.tag = cyc + 1;
    e.res = use_k ? k : m_res;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.start = 1'b0;
    bus.op1 = $urandom; bus.op2 = $urandom; bus.imm_data = $urandom;
    repeat (n) @(negedge clk);
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] i, input logic [31:0] d);
    issue(2'b10, 3'd2, 2'b00, a, i, d, 1'b0, 32'h0);
  endtask

  task automatic ld(input logic [2:0] m2, input logic [1:0] m1, input logic [31:0] a,
                    input logic [31:0] i, input logic [31:0] k);
    issue(2'b01, m2, m1, a, i, 32'h0, 1'b1, k);
  endtask

  initial begin
    for (int k = 0; k < NBYTES; k++) mm[k] = 8'h0;
    m_res = 32'h0;
    bus.start = 1'b0; bus.use_part = 2'b00; bus.op_mode1 = 2'b00; bus.op_mode2 = 3'd0;
    bus.op1 = 32'h0; bus.op2 = 32'h0; bus.imm_data = 32'h0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    mon_on = 1'b1;
    check("reset_res", bus.res, 32'h0);

    // Clear the array (power-up value is zero) back-to-back.
    for (int w = 0; w < DEPTH; w++) sw(32'(4 * w), 32'h0, 32'h0);

    // Reset held two cycles with a store strobed: dropped, nothing written.
    rst = 1'b0;
    bus.start = 1'b1; bus.use_part = 2'b10; bus.op_mode2 = 3'd2; bus.op_mode1 = 2'b00;
    bus.op1 = 32'h0; bus.imm_data = 32'h0; bus.op2 = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_res = 32'h0;
    bus.start = 1'b0;
    @(negedge clk);
    check("rst_res", bus.res, 32'h0);
    ld(3'd2, 2'b00, 32'h0, 32'h0, 32'h0);

    // Word store/load with misaligned EA.
    sw(32'h0, 32'h3, 32'hFFFF_FFFF);
    idle(1);
    ld(3'd2, 2'b00, 32'h0, 32'h3, 32'hFFFF_FFFF);
    idle(2);

    // Sign and zero extension.
    sw(32'h0, 32'h0, 32'h8001_7F80);
    ld(3'd0, 2'b00, 32'h0, 32'h0, 32'hFFFF_FF80);
    ld(3'd4, 2'b00, 32'h0, 32'h0, 32'h0000_0080);
    ld(3'd1, 2'b00, 32'h0, 32'h2, 32'hFFFF_8001);
    ld(3'd5, 2'b00, 32'h0, 32'h2, 32'h0000_8001);

    // Partial stores merge into one word.
    sw(32'h8, 32'h0, 32'h0);
    issue(2'b10, 3'd0, 2'b00, 32'h9, 32'h0, 32'h1234_56AB, 1'b0, 32'h0);
    issue(2'b10, 3'd1, 2'b00, 32'hA, 32'h0, 32'h0000_CDEF, 1'b0, 32'h0);
    ld(3'd2, 2'b00, 32'h8, 32'h0, 32'hCDEF_AB00);

    // Address modes and wrap.
    issue(2'b10, 3'd2, 2'b10, 32'h0000_0100, 32'(NBYTES + 4), 32'h1111_2222, 1'b0, 32'h0);
    ld(3'd2, 2'b00, 32'h4, 32'h0, 32'h1111_2222);
    ld(3'd2, 2'b01, 32'h8, 32'h5555_0000, 32'hCDEF_AB00);
    ld(3'd2, 2'b00, 32'hFFFF_FFFC, 32'h4, 32'h8001_7F80);
    idle(1);

    // Pipelined run, RAW, no-op, reserved encodings.
    sw(32'hC, 32'h0, 32'hA5A5_5A5A);
    ld(3'd2, 2'b00, 32'hC, 32'h0, 32'hA5A5_5A5A);
    ld(3'd2, 2'b00, 32'h0, 32'h0, 32'h8001_7F80);
    issue(2'b00, 3'd2, 2'b00, 32'h0, 32'h0, 32'h7777_7777, 1'b1, 32'h8001_7F80);
    issue(2'b11, 3'd2, 2'b00, 32'h0, 32'h0, 32'h7777_7777, 1'b1, 32'h8001_7F80);
    issue(2'b10, 3'd3, 2'b00, 32'h0, 32'h0, 32'h7777_7777, 1'b1, 32'h8001_7F80);
    ld(3'd2, 2'b00, 32'h0, 32'h0, 32'h8001_7F80);
    ld(3'd3, 2'b00, 32'h0, 32'h0, 32'h0);
    ld(3'd6, 2'b00, 32'hC, 32'h0, 32'h0);
    idle(2);

    // Random traffic, half of it confined to a few words for RAW hits.
    for (int n = 0; n < 3000; n++) begin
      logic [1:0]  up, m1;
      logic [31:0] a, i;
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      up = 2'($urandom);
      m1 = 2'($urandom);
      a  = $urandom;
      i  = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        up = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
        m1 = 2'b00; a = 32'($urandom_range(0, 63)); i = 32'h0;
      end
      issue(up, 3'($urandom), m1, a, i, $urandom, 1'b0, 32'h0);
    end

    idle(4);
    check("queue_empty", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
